// File: rtl/memory_access_sequencer.sv
// memory_access_sequencer
//   Takes one load or store request at a time from the core and sequences the
//   memory controller through NOP/LOAD/STORE_PRELOAD/STORE. Sub-word stores
//   first preload the target word (read-modify-write). A word store needs only
//   one preload cycle. An illegal width code or an unaligned address moves the
//   block into a sticky ERROR state.
//
//   Ports
//     clock, reset           single clock; asynchronous active-high reset
//     req_valid/req_ready    request handshake; accepted only in IDLE
//     req_is_store           1 = store, 0 = load (sampled on acceptance)
//     req_funct3             width code (sampled on acceptance)
//     memoryUnalignedAccess  unaligned flag from the controller (combinational)
//     memoryMode             command to the memory controller
//     funct3                 latched width code, driven to the controller
//     done, load_valid       completion pulse; load_valid marks a load
//     busy, error            activity and sticky fault flags

package mas_pkg;
  typedef enum logic [1:0] {
    MM_NOP           = 2'd0,
    MM_LOAD          = 2'd1,
    MM_STORE_PRELOAD = 2'd2,
    MM_STORE         = 2'd3
  } MemoryMode_t;
endpackage

module memory_access_sequencer
  import mas_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic        memoryUnalignedAccess,
  output logic        req_ready,
  output MemoryMode_t memoryMode,
  output logic [2:0]  funct3,
  output logic        done,
  output logic        load_valid,
  output logic        busy,
  output logic        error
);

  localparam int CW = $clog2(READ_LATENCY + 1);
  localparam logic [CW-1:0] LAST = CW'(READ_LATENCY - 1);
  localparam logic [CW-1:0] CMAX = CW'(READ_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PRELOAD, S_STORE, S_DONE, S_ERROR
  } state_t;

  state_t        state, state_d;
  logic          store_q;
  logic [2:0]    funct3_q;
  logic [CW-1:0] cnt;
  logic          legal;
  logic          first;

  // Loads: byte/half/word signed and byte/half unsigned. Stores: byte/half/word.
  always_comb begin
    legal = 1'b0;
    if (req_is_store) legal = (req_funct3 inside {3'b000, 3'b001, 3'b010});
    else              legal = !(req_funct3 inside {3'b011, 3'b110, 3'b111});
  end

  // The counter is cleared on every state change, so zero marks the first
  // cycle of LOAD/PRELOAD. This is the only cycle in which the unaligned flag
  // is examined.
  assign first = (cnt == '0);

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (!legal)            state_d = S_ERROR;
          else if (req_is_store) state_d = S_PRELOAD;
          else                   state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (first && memoryUnalignedAccess) state_d = S_ERROR;
        else if (cnt == LAST)               state_d = S_DONE;
      end
      S_PRELOAD: begin
        // A full-word store overwrites the whole word, so the preload data is
        // not needed. One preload cycle is enough to capture the unaligned flag.
        if (first && memoryUnalignedAccess)           state_d = S_ERROR;
        else if (funct3_q == 3'b010 || cnt == LAST)   state_d = S_STORE;
      end
      S_STORE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      store_q  <= 1'b0;
      funct3_q <= 3'b000;
    end else if (state == S_IDLE && req_valid) begin
      store_q  <= req_is_store;
      funct3_q <= req_funct3;
    end
  end

  // Counts LOAD/PRELOAD cycles. It saturates instead of wrapping, although
  // the state exits before the counter reaches its maximum.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (state_d != state)
      cnt <= '0;
    else if ((state == S_LOAD || state == S_PRELOAD) && cnt != CMAX)
      cnt <= cnt + 1'b1;
  end

  always_comb begin
    memoryMode = MM_NOP;
    case (state)
      S_LOAD:    memoryMode = MM_LOAD;
      S_PRELOAD: memoryMode = MM_STORE_PRELOAD;
      S_STORE:   memoryMode = MM_STORE;
      default:   memoryMode = MM_NOP;
    endcase
  end

  assign req_ready  = (state == S_IDLE);
  assign done       = (state == S_DONE);
  assign load_valid = (state == S_DONE) && !store_q;
  assign busy       = !(state == S_IDLE || state == S_ERROR);
  assign error      = (state == S_ERROR);
  assign funct3     = funct3_q;

endmodule

// File: tb/tb_memory_access_sequencer.sv
// Bench for memory_access_sequencer. Three instances (READ_LATENCY 1, 2, 3)
// are driven independently. For each request, a reference model expands the
// request into the expected per-cycle output trace. The model derives this
// trace from the request rules (legality, word vs sub-word, unaligned flag).
module tb_memory_access_sequencer;
  import mas_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [2:0] rst = 3'b111;
  logic [2:0] req_valid = '0, req_is_store = '0, unal = '0;
  logic [2:0] req_f3 [3] = '{3'd0, 3'd0, 3'd0};
  wire  [1:0] mm  [3];
  wire  [2:0] f3o [3];
  wire  [2:0] ready, done, lv, busy, err;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    memory_access_sequencer #(.READ_LATENCY(g + 1)) u_dut (
      .clock(clock), .reset(rst[g]),
      .req_valid(req_valid[g]), .req_is_store(req_is_store[g]),
      .req_funct3(req_f3[g]), .memoryUnalignedAccess(unal[g]),
      .req_ready(ready[g]), .memoryMode(mm[g]), .funct3(f3o[g]),
      .done(done[g]), .load_valid(lv[g]), .busy(busy[g]), .error(err[g])
    );
  end

  typedef struct {
    logic [1:0] mode;
    logic       rdy, dn, lv, bsy, er;
    logic [2:0] f3;
  } exp_t;

  int         checks = 0, errors = 0;
  int         rl [3] = '{1, 2, 3};
  logic [2:0] mf3 [3] = '{3'd0, 3'd0, 3'd0};
  exp_t       eq [$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(logic [1:0] mode, logic rdy, logic dn, logic l,
                              logic bsy, logic er, logic [2:0] f3);
    exp_t e;
    e.mode = mode; e.rdy = rdy; e.dn = dn; e.lv = l; e.bsy = bsy; e.er = er; e.f3 = f3;
    return e;
  endfunction

  task automatic check_entry(int d, exp_t e, string tag);
    chk($sformatf("%s d%0d mode", tag, d), 32'(mm[d]), 32'(e.mode));
    chk($sformatf("%s d%0d ready", tag, d), 32'(ready[d]), 32'(e.rdy));
    chk($sformatf("%s d%0d done", tag, d), 32'(done[d]), 32'(e.dn));
    chk($sformatf("%s d%0d load_valid", tag, d), 32'(lv[d]), 32'(e.lv));
    chk($sformatf("%s d%0d busy", tag, d), 32'(busy[d]), 32'(e.bsy));
    chk($sformatf("%s d%0d error", tag, d), 32'(err[d]), 32'(e.er));
    chk($sformatf("%s d%0d funct3", tag, d), 32'(f3o[d]), 32'(e.f3));
  endtask

  // Expand one accepted request into the cycles that follow acceptance.
  task automatic build(int d, bit st, logic [2:0] f3, bit un, output bit ends_err);
    bit   legal;
    int   n_act;
    logic [1:0] am;
    eq.delete();
    legal = st ? (f3 <= 3'd2) : !(f3 == 3'd3 || f3 >= 3'd6);
    am    = st ? 2'(MM_STORE_PRELOAD) : 2'(MM_LOAD);
    n_act = (st && f3 == 3'd2) ? 1 : rl[d];
    ends_err = !legal || un;
    if (legal) begin
      if (un) eq.push_back(mk(am, 0, 0, 0, 1, 0, f3));
      else for (int k = 0; k < n_act; k++) eq.push_back(mk(am, 0, 0, 0, 1, 0, f3));
    end
    if (ends_err) begin
      for (int k = 0; k < 4; k++) eq.push_back(mk(2'(MM_NOP), 0, 0, 0, 0, 1, f3));
    end else begin
      if (st) eq.push_back(mk(2'(MM_STORE), 0, 0, 0, 1, 0, f3));
      eq.push_back(mk(2'(MM_NOP), 0, 1, !st, 1, 0, f3));
      eq.push_back(mk(2'(MM_NOP), 1, 0, 0, 0, 0, f3));
    end
  endtask

  // Entered just after a negedge. Exits one idle cycle after release, at a negedge.
  task automatic do_reset(int d, string tag);
    req_valid[d] = 1'b0;
    #2 rst[d] = 1'b1;
    mf3[d] = 3'd0;
    #1 check_entry(d, mk(2'(MM_NOP), 1, 0, 0, 0, 0, 3'd0), {tag, " rst-async"});
    @(posedge clock); #2;
    check_entry(d, mk(2'(MM_NOP), 1, 0, 0, 0, 0, 3'd0), {tag, " rst-held"});
    @(negedge clock) rst[d] = 1'b0;
    @(negedge clock);
    check_entry(d, mk(2'(MM_NOP), 1, 0, 0, 0, 0, 3'd0), {tag, " post-rst"});
  endtask

  // Entered at a negedge with the instance idle. abort_at >= 0 resets the
  // instance after that trace entry has been checked.
  task automatic run_req(int d, bit st, logic [2:0] f3, bit un, string tag, int abort_at);
    bit ends_err;
    chk($sformatf("%s d%0d ready-before", tag, d), 32'(ready[d]), 32'd1);
    build(d, st, f3, un, ends_err);
    req_valid[d] = 1'b1; req_is_store[d] = st; req_f3[d] = f3;
    unal[d] = 1'($urandom_range(0, 1));
    mf3[d] = f3;
    for (int i = 0; i < eq.size(); i++) begin
      @(negedge clock);
      check_entry(d, eq[i], $sformatf("%s c%0d", tag, i + 1));
      if (i == abort_at) begin
        do_reset(d, tag);
        return;
      end
      if (eq[i].rdy) req_valid[d] = 1'b0;
      else begin
        req_valid[d]    = 1'($urandom_range(0, 1));
        req_is_store[d] = 1'($urandom_range(0, 1));
        req_f3[d]       = 3'($urandom_range(0, 7));
      end
      unal[d] = (i == 0) ? un : 1'($urandom_range(0, 1));
    end
    if (ends_err) do_reset(d, tag);
  endtask

  initial begin
    @(negedge clock);
    for (int d = 0; d < 3; d++) do_reset(d, "init");

    run_req(0, 0, 3'b010, 0, "load_rl1", -1);
    run_req(2, 1, 3'b000, 0, "sb_rl3", -1);
    run_req(0, 1, 3'b010, 1, "sw_unal_rl1", -1);
    run_req(1, 1, 3'b010, 1, "sw_unal_rl2", -1);
    run_req(0, 0, 3'b011, 0, "ld_f3_011", -1);
    run_req(2, 1, 3'b100, 0, "st_f3_100", -1);
    run_req(2, 1, 3'b001, 0, "sh_abort_pre", 1);
    run_req(2, 0, 3'b010, 0, "ld_after_abort", -1);
    run_req(0, 1, 3'b010, 0, "sw_abort_store", 1);
    run_req(0, 0, 3'b100, 0, "lbu_after_abort", -1);
    run_req(2, 0, 3'b001, 1, "lh_unal_rl3", -1);

    // Continuous req_valid with word loads at READ_LATENCY=2: one acceptance
    // every four cycles (IDLE, LOAD, LOAD, DONE).
    req_valid[1] = 1'b1; req_is_store[1] = 1'b0; req_f3[1] = 3'b010; unal[1] = 1'b0;
    mf3[1] = 3'b010;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clock);
      chk($sformatf("hold c%0d ready", c), 32'(ready[1]), 32'(c % 4 == 0));
      chk($sformatf("hold c%0d done", c), 32'(done[1]), 32'(c % 4 == 3));
      chk($sformatf("hold c%0d mode", c), 32'(mm[1]),
          (c % 4 == 1 || c % 4 == 2) ? 32'(MM_LOAD) : 32'(MM_NOP));
    end
    req_valid[1] = 1'b0;
    @(negedge clock);
    check_entry(1, mk(2'(MM_NOP), 1, 0, 0, 0, 0, 3'b010), "hold-end");

    for (int n = 0; n < 30; n++) begin
      for (int d = 0; d < 3; d++) begin
        run_req(d, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                $urandom_range(0, 7) == 0, $sformatf("rnd%0d", n), -1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
